// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU among NUM_REQ requesters. Each requester
//   presents a valid/ready request. One winner per cycle is muxed into the
//   ALU. Its result is captured, tagged with the requester id, in a single
//   registered response slot that the consumer drains with i_rsp_ready.
//
//   Build option:
//     ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                         and no round-robin pointer exists.
//                            undefined -> round-robin starting at ptr.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req_valid[k]     request valid from requester k
//   o_req_ready[k]     accept strobe to requester k (one-hot or zero)
//   i_req_opsel        3 bits per requester, slice [3*k+:3]
//   i_req_sub          add/sub select per requester
//   i_req_unsigned     unsigned-compare select per requester
//   i_req_arith        arithmetic-shift select per requester
//   i_req_op1/op2      32-bit operands per requester, slice [32*k+:32]
//   o_rsp_valid        response slot occupied
//   i_rsp_ready        consumer drains the slot this cycle
//   o_rsp_id           requester that owns the response
//   o_rsp_result       registered ALU result
//   o_rsp_eq/o_rsp_slt registered ALU compare flags
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_arbiter_alu
//   Combinational ALU shared by all requesters.
//   opsel: 000 add/sub, 001 sll, 010/011 slt, 100 xor, 101 srl/sra,
//          110 or, 111 and. Shift amount is op2[4:0]. o_eq and o_slt are
//          produced for every opsel.
// ---------------------------------------------------------------------------
module alu_arbiter_alu (
    input  logic [2:0]  i_opsel,
    input  logic        i_sub,
    input  logic        i_unsigned,
    input  logic        i_arith,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic [31:0] o_result,
    output logic        o_eq,
    output logic        o_slt
);
    logic [31:0]        addsub;
    logic [4:0]         shamt;
    logic               lt;
    // Kept as its own signed net: inside a ternary with an unsigned arm the
    // >>> would silently degrade to a logical shift.
    logic signed [31:0] sra_res;

    assign shamt   = i_op2[4:0];
    assign addsub  = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
    assign lt      = i_unsigned ? (i_op1 < i_op2)
                                : ($signed(i_op1) < $signed(i_op2));
    assign sra_res = $signed(i_op1) >>> shamt;

    assign o_eq  = (i_op1 == i_op2);
    assign o_slt = lt;

    always_comb begin
        o_result = '0;
        case (i_opsel)
            3'b000:  o_result = addsub;
            3'b001:  o_result = i_op1 << shamt;
            3'b010,
            3'b011:  o_result = {31'b0, lt};
            3'b100:  o_result = i_op1 ^ i_op2;
            3'b101:  o_result = i_arith ? sra_res : (i_op1 >> shamt);
            3'b110:  o_result = i_op1 | i_op2;
            default: o_result = i_op1 & i_op2;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [3*NUM_REQ-1:0]    i_req_opsel,
    input  logic [NUM_REQ-1:0]      i_req_sub,
    input  logic [NUM_REQ-1:0]      i_req_unsigned,
    input  logic [NUM_REQ-1:0]      i_req_arith,
    input  logic [32*NUM_REQ-1:0]   i_req_op1,
    input  logic [32*NUM_REQ-1:0]   i_req_op2,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [31:0]             o_rsp_result,
    output logic                    o_rsp_eq,
    output logic                    o_rsp_slt
);
    // -----------------------------------------------------------------------
    // Response slot state
    // -----------------------------------------------------------------------
    logic            rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_eq_q,     rsp_eq_d;
    logic            rsp_slt_q,    rsp_slt_d;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic            slot_free;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] scan_idx;
    logic            accept;

    // A slot draining this cycle can be refilled on the same edge, which is
    // what gives one op per cycle under continuous i_rsp_ready.
    assign slot_free = !rsp_valid_q || i_rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'(i);
            if (!gnt_found && i_req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   scan_sum;   // one spare bit so ptr+i cannot wrap early

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        scan_sum  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (scan_sum >= (ID_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            scan_idx = scan_sum[ID_W-1:0];
            if (!gnt_found && i_req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    // The pointer moves just past the requester that was served, so a
    // continuously valid requester waits at most NUM_REQ-1 accepts.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (gnt_id == ID_W'(NUM_REQ - 1))
                ptr_d = '0;
            else
                ptr_d = gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end
`endif

    // Ready is a function of valids, ptr and slot state only; the payload
    // never feeds it. Held low for the whole reset cycle.
    always_comb begin
        o_req_ready = '0;
        if (!i_rst && gnt_found && slot_free)
            o_req_ready[gnt_id] = 1'b1;
    end

    assign accept = |(o_req_ready & i_req_valid);

    // -----------------------------------------------------------------------
    // Payload mux into the single ALU
    // -----------------------------------------------------------------------
    logic [2:0]  mux_opsel;
    logic        mux_sub;
    logic        mux_unsigned;
    logic        mux_arith;
    logic [31:0] mux_op1;
    logic [31:0] mux_op2;
    logic [31:0] alu_result;
    logic        alu_eq;
    logic        alu_slt;

    assign mux_opsel    = i_req_opsel[3*gnt_id +: 3];
    assign mux_sub      = i_req_sub[gnt_id];
    assign mux_unsigned = i_req_unsigned[gnt_id];
    assign mux_arith    = i_req_arith[gnt_id];
    assign mux_op1      = i_req_op1[32*gnt_id +: 32];
    assign mux_op2      = i_req_op2[32*gnt_id +: 32];

    alu_arbiter_alu u_alu (
        .i_opsel    (mux_opsel),
        .i_sub      (mux_sub),
        .i_unsigned (mux_unsigned),
        .i_arith    (mux_arith),
        .i_op1      (mux_op1),
        .i_op2      (mux_op2),
        .o_result   (alu_result),
        .o_eq       (alu_eq),
        .o_slt      (alu_slt)
    );

    // -----------------------------------------------------------------------
    // Response slot next state
    //   accept           -> load new result, slot stays/becomes valid
    //   drain, no accept -> slot empties, data registers hold
    //   otherwise        -> hold everything
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_slt_d    = rsp_slt_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_id;
            rsp_result_d = alu_result;
            rsp_eq_d     = alu_eq;
            rsp_slt_d    = alu_slt;
        end else if (i_rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_eq_q     <= 1'b0;
            rsp_slt_q    <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_slt_q    <= rsp_slt_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_eq     = rsp_eq_q;
    assign o_rsp_slt    = rsp_slt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = $clog2(NREQ);

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_opsel;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      req_uns;
    logic [NREQ-1:0]      req_arith;
    logic [32*NREQ-1:0]   req_op1;
    logic [32*NREQ-1:0]   req_op2;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_eq;
    logic                 rsp_slt;

    alu_arbiter #(.NUM_REQ(NREQ)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_opsel    (req_opsel),
        .i_req_sub      (req_sub),
        .i_req_unsigned (req_uns),
        .i_req_arith    (req_arith),
        .i_req_op1      (req_op1),
        .i_req_op2      (req_op2),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_id       (rsp_id),
        .o_rsp_result   (rsp_result),
        .o_rsp_eq       (rsp_eq),
        .o_rsp_slt      (rsp_slt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: contents of the response slot and the rotation start.
    bit          m_valid;
    int          m_id;
    logic [31:0] m_res;
    bit          m_eq;
    bit          m_slt;
    int          m_ptr;
    int          last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ALU behaviour from plain 64-bit arithmetic.
    task automatic ref_alu(input logic [2:0] op, input bit sb, input bit un, input bit ar,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output bit e, output bit l);
        longint ua, ub, sa, sbv, p2;
        int sh;
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sa  = (a[31]) ? ua - 64'sd4294967296 : ua;
        sbv = (b[31]) ? ub - 64'sd4294967296 : ub;
        sh  = int'(ub % 32);
        p2  = 64'sd1 << sh;
        e   = (ua == ub);
        l   = un ? (ua < ub) : (sa < sbv);
        case (op)
            3'd0: r = sb ? 32'(ua - ub) : 32'(ua + ub);
            3'd1: r = 32'(ua * p2);
            3'd2, 3'd3: r = l ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (ar && sa < 0) r = 32'(-((-sa + p2 - 1) / p2)); // floor division
                else              r = 32'(ua / p2);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
    endtask

    function automatic int pick();
        int k;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (m_ptr + i) % NREQ;
`endif
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    // One clock: entered at a negedge with inputs already driven.
    task automatic cycle();
        int w;
        logic [NREQ-1:0] rdy_exp;
        bit free;
        logic [31:0] r;
        bit e, l;
        #1;
        free    = !m_valid || rsp_ready;
        w       = pick();
        rdy_exp = '0;
        if (!rst && free && w >= 0) rdy_exp[w] = 1'b1;
        chk("req_ready",  32'(req_ready),  32'(rdy_exp));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_valid));
        chk("rsp_id",     32'(rsp_id),     32'(m_id));
        chk("rsp_result", rsp_result,      m_res);
        chk("rsp_eq",     32'(rsp_eq),     32'(m_eq));
        chk("rsp_slt",    32'(rsp_slt),    32'(m_slt));
        last_acc = -1;
        if (rst) begin
            m_valid = 0; m_id = 0; m_res = '0; m_eq = 0; m_slt = 0; m_ptr = 0;
        end else if (rdy_exp != '0) begin
            ref_alu(req_opsel[3*w +: 3], req_sub[w], req_uns[w], req_arith[w],
                    req_op1[32*w +: 32], req_op2[32*w +: 32], r, e, l);
            m_valid = 1; m_id = w; m_res = r; m_eq = e; m_slt = l;
            m_ptr = (w + 1) % NREQ;
            last_acc = w;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input bit v, input logic [2:0] op, input bit sb,
                           input bit un, input bit ar, input logic [31:0] a, input logic [31:0] b);
        req_valid[k]         = v;
        req_opsel[3*k +: 3]  = op;
        req_sub[k]           = sb;
        req_uns[k]           = un;
        req_arith[k]         = ar;
        req_op1[32*k +: 32]  = a;
        req_op2[32*k +: 32]  = b;
    endtask

    task automatic rand_req(input int k);
        logic [31:0] a, b;
        int mode;
        a    = $urandom;
        mode = $urandom_range(3);
        b    = (mode == 0) ? a : (mode == 1) ? 32'($urandom_range(40)) : $urandom;
        set_req(k, ($urandom_range(9) < 6), 3'($urandom_range(7)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)), a, b);
    endtask

    logic [31:0] held;
    int exp_ids[4];

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req_valid = '0; req_opsel = '0; req_sub = '0; req_uns = '0; req_arith = '0;
        req_op1 = '0; req_op2 = '0;
        m_valid = 0; m_id = 0; m_res = '0; m_eq = 0; m_slt = 0; m_ptr = 0; last_acc = -1;
        @(posedge clk); @(negedge clk);   // first reset edge, state defined from here

        // Reset held 2 cycles with every requester valid.
        req_valid = '1; rsp_ready = 1'($urandom_range(1));
        repeat (2) cycle();
        rst = 1'b0; req_valid = '0;

        // Single op: 5 - 7.
        rsp_ready = 1'b1;
        set_req(0, 1, 3'b000, 1, 0, 0, 32'd5, 32'd7);
        cycle();
        chk("t2_valid",  32'(rsp_valid), 32'd1);
        chk("t2_id",     32'(rsp_id),    32'd0);
        chk("t2_result", rsp_result,     32'hFFFF_FFFE);
        chk("t2_eq",     32'(rsp_eq),    32'd0);
        chk("t2_slt",    32'(rsp_slt),   32'd1);
        req_valid = '0;

        // Round-robin from a fresh pointer.
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1, 3'b000, 0, 0, 0, 32'd1, 32'd2);
        set_req(1, 1, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_id", 32'(rsp_id), 32'(i % 2));
            chk("t3_result", rsp_result, (i % 2) ? 32'hF800_0000 : 32'd3);
        end

        // Backpressure: accept, stall 3 cycles, release.
        req_valid = '0;
        set_req(0, 1, 3'b100, 0, 0, 0, 32'h0F0F_0F0F, 32'hFFFF_0000);
        cycle();
        held = rsp_result;
        chk("t4_first", held, 32'hF0F0_0F0F);
        rsp_ready = 1'b0; req_valid = '1;
        repeat (3) begin
            #1 chk("t4_stall_ready", 32'(req_ready), 32'd0);
            cycle();
            chk("t4_hold", rsp_result, held);
        end
        rsp_ready = 1'b1;
        #1 chk("t4_release_ready", 32'(req_ready), 32'd2);
        cycle();
        chk("t4_release_id", 32'(rsp_id), 32'd1);

        // Unsigned vs signed compare.
        req_valid = '0;
        set_req(0, 1, 3'b011, 0, 1, 0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("t5u_result", rsp_result, 32'd0);
        chk("t5u_slt",    32'(rsp_slt), 32'd0);
        set_req(0, 1, 3'b011, 0, 0, 0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("t5s_result", rsp_result, 32'd1);
        chk("t5s_slt",    32'(rsp_slt), 32'd1);

        // Reset mid-operation.
        set_req(0, 1, 3'b110, 0, 0, 0, 32'h1234_0000, 32'h0000_5678);
        cycle();
        chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
        req_valid = '0; rsp_ready = 1'b0; rst = 1'b1;
        cycle();
        chk("t6_post_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0; rsp_ready = 1'b1; req_valid = '1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_order", 32'(rsp_id), 32'(exp_ids[i]));
        end

        // Randomized traffic: requesters hold until accepted, occasionally drop.
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || last_acc == k) rand_req(k);
                else if ($urandom_range(19) == 0) req_valid[k] = 1'b0;
            end
            rsp_ready = ($urandom_range(9) < 7);
            rst       = ($urandom_range(63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
